// File: rtl/isram_arbiter_pkg.sv
// Shared definitions for the instruction-SRAM arbiter: bus widths and the
// encoding that tags which requester owns the read beat in flight.
package isram_arbiter_pkg;

    localparam int ISRAM_AW = 29;
    localparam int ISRAM_DW = 64;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_EXT   = 2'd2
    } rd_owner_e;

endpackage

// File: rtl/isram_arbiter_starve_cnt.sv
// Saturating count of consecutive cycles the secondary requester was denied;
// starve_hit forces the next grant to the secondary requester.
module arb_starve_cnt #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic cpurst,
    input  logic ext_req,
    input  logic ext_gnt,
    output logic starve_hit
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (!ext_req || ext_gnt) begin
            cnt_next = 4'd0;
        end else if (cnt_reg != LIMIT) begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            cnt_reg <= 4'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign starve_hit = (cnt_reg == LIMIT);

endmodule

// File: rtl/isram_arbiter.sv
// Arbitrates the single instruction-SRAM port between fetch (priority) and a
// secondary requester, and routes each returned read beat to its owner.
module isram_arbiter
    import isram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                cpurst,
    input  logic                isram_cs,
    input  logic [31:3]         isram_adr,
    output logic [ISRAM_DW-1:0] instr_fromsram,
    output logic                fet_arb_stall,
    input  logic                ext_req,
    input  logic                ext_we,
    input  logic [31:3]         ext_adr,
    input  logic [ISRAM_DW-1:0] ext_wdata,
    input  logic [7:0]          ext_wmask,
    output logic                ext_gnt,
    output logic                ext_rvalid,
    output logic [ISRAM_DW-1:0] ext_rdata,
    output logic                sram_cs,
    output logic                sram_we,
    output logic [31:3]         sram_adr,
    output logic [ISRAM_DW-1:0] sram_wdata,
    output logic [7:0]          sram_wmask,
    input  logic [ISRAM_DW-1:0] sram_rdata
);

    logic          starve_hit;
    logic          fet_gnt;
    rd_owner_e     rd_owner_reg;
    rd_owner_e     rd_owner_next;
    logic [ISRAM_DW-1:0] fet_hold_reg;

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk        (clk),
        .cpurst     (cpurst),
        .ext_req    (ext_req),
        .ext_gnt    (ext_gnt),
        .starve_hit (starve_hit)
    );

    assign ext_gnt       = !cpurst && ext_req && (!isram_cs || starve_hit);
    assign fet_gnt       = !cpurst && isram_cs && !ext_gnt;
    assign fet_arb_stall = !cpurst && isram_cs && ext_gnt;

    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_adr   = '0;
        sram_wdata = '0;
        sram_wmask = '0;
        if (ext_gnt) begin
            sram_cs    = 1'b1;
            sram_we    = ext_we;
            sram_adr   = ext_adr;
            sram_wdata = ext_wdata;
            sram_wmask = ext_wmask;
        end else if (fet_gnt) begin
            sram_cs  = 1'b1;
            sram_adr = isram_adr;
        end
    end

    // A granted write returns no beat, so it leaves the return path idle.
    always_comb begin
        rd_owner_next = OWN_NONE;
        if (fet_gnt) begin
            rd_owner_next = OWN_FETCH;
        end else if (ext_gnt && !ext_we) begin
            rd_owner_next = OWN_EXT;
        end
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            rd_owner_reg <= OWN_NONE;
            fet_hold_reg <= '0;
        end else begin
            rd_owner_reg <= rd_owner_next;
            if (rd_owner_reg == OWN_FETCH) begin
                fet_hold_reg <= sram_rdata;
            end
        end
    end

    // Returned data is masked while reset is held so a beat in flight is dropped.
    assign ext_rvalid = !cpurst && (rd_owner_reg == OWN_EXT);
    assign ext_rdata  = ext_rvalid ? sram_rdata : '0;

    always_comb begin
        instr_fromsram = fet_hold_reg;
        if (cpurst) begin
            instr_fromsram = '0;
        end else if (rd_owner_reg == OWN_FETCH) begin
            instr_fromsram = sram_rdata;
        end
    end

endmodule

// File: tb/tb_isram_arbiter.sv
// Scoreboard bench: grants are predicted per cycle, the owner and data of each
// read beat are queued at grant time and compared when the beat returns.
module tb_isram_arbiter;
    import isram_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        isram_cs;
    logic [31:3] isram_adr;
    logic [63:0] instr_fromsram;
    logic        fet_arb_stall;
    logic        ext_req;
    logic        ext_we;
    logic [31:3] ext_adr;
    logic [63:0] ext_wdata;
    logic [7:0]  ext_wmask;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [63:0] ext_rdata;
    logic        sram_cs;
    logic        sram_we;
    logic [31:3] sram_adr;
    logic [63:0] sram_wdata;
    logic [7:0]  sram_wmask;
    logic [63:0] sram_rdata = 64'd0;

    always #5 clk = ~clk;

    isram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .cpurst         (cpurst),
        .isram_cs       (isram_cs),
        .isram_adr      (isram_adr),
        .instr_fromsram (instr_fromsram),
        .fet_arb_stall  (fet_arb_stall),
        .ext_req        (ext_req),
        .ext_we         (ext_we),
        .ext_adr        (ext_adr),
        .ext_wdata      (ext_wdata),
        .ext_wmask      (ext_wmask),
        .ext_gnt        (ext_gnt),
        .ext_rvalid     (ext_rvalid),
        .ext_rdata      (ext_rdata),
        .sram_cs        (sram_cs),
        .sram_we        (sram_we),
        .sram_adr       (sram_adr),
        .sram_wdata     (sram_wdata),
        .sram_wmask     (sram_wmask),
        .sram_rdata     (sram_rdata)
    );

    // SRAM macro stand-in driven only by the DUT's port.
    logic [63:0] mem [256];
    logic [63:0] exp_mem [256];

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 8; b++) begin
                    if (sram_wmask[b]) mem[sram_adr[10:3]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_adr[10:3]];
            end
        end
    end

    typedef struct {
        logic [1:0]  owner;
        logic [63:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          model_cnt = 0;
    logic [63:0] model_hold = 64'd0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic cs, input logic [28:0] fadr, input logic req,
                        input logic we, input logic [28:0] eadr,
                        input logic [63:0] wd, input logic [7:0] wm);
        exp_t        r;
        exp_t        e;
        logic        eg;
        logic        fg;
        logic [28:0] xadr;
        cpurst    = 1'b0;
        isram_cs  = cs;
        isram_adr = fadr;
        ext_req   = req;
        ext_we    = we;
        ext_adr   = eadr;
        ext_wdata = wd;
        ext_wmask = wm;
        #3;
        r.owner = 2'(OWN_NONE);
        r.data  = 64'd0;
        if (sb_q.size() != 0) r = sb_q.pop_front();
        check_val("ext_rvalid", 64'(ext_rvalid), 64'(r.owner == 2'(OWN_EXT)));
        check_val("ext_rdata", ext_rdata, (r.owner == 2'(OWN_EXT)) ? r.data : 64'd0);
        if (r.owner == 2'(OWN_FETCH)) model_hold = r.data;
        check_val("instr_fromsram", instr_fromsram, model_hold);

        eg = req && (!cs || model_cnt == LIMIT);
        fg = cs && !eg;
        check_val("ext_gnt", 64'(ext_gnt), 64'(eg));
        check_val("fet_arb_stall", 64'(fet_arb_stall), 64'(cs && eg));
        check_val("sram_cs", 64'(sram_cs), 64'(eg || fg));
        check_val("sram_we", 64'(sram_we), 64'(eg && we));
        xadr = eg ? eadr : (fg ? fadr : 29'd0);
        check_val("sram_adr", 64'(sram_adr), 64'(xadr));
        check_val("sram_wdata", sram_wdata, eg ? wd : 64'd0);
        check_val("sram_wmask", 64'(sram_wmask), eg ? 64'(wm) : 64'd0);
        $display("t=%0t cs=%b fadr=%h req=%b we=%b eadr=%h | gnt=%b stall=%b rvalid=%b rdata=%h instr=%h",
                 $time, cs, fadr, req, we, eadr, ext_gnt, fet_arb_stall, ext_rvalid, ext_rdata, instr_fromsram);

        e.owner = fg ? 2'(OWN_FETCH) : ((eg && !we) ? 2'(OWN_EXT) : 2'(OWN_NONE));
        e.data  = fg ? exp_mem[fadr[7:0]] : ((eg && !we) ? exp_mem[eadr[7:0]] : 64'd0);
        sb_q.push_back(e);
        if (eg && we) begin
            for (int b = 0; b < 8; b++) begin
                if (wm[b]) exp_mem[eadr[7:0]][b*8 +: 8] = wd[b*8 +: 8];
            end
        end
        if (!req || eg) model_cnt = 0;
        else if (model_cnt < LIMIT) model_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Requests stay asserted during reset to show the grants are gated.
    task automatic reset_cycle();
        exp_t e;
        cpurst    = 1'b1;
        isram_cs  = 1'b1;
        isram_adr = 29'h5;
        ext_req   = 1'b1;
        ext_we    = 1'b0;
        ext_adr   = 29'h6;
        ext_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        ext_wmask = 8'hFF;
        #3;
        check_val("rst_ext_gnt", 64'(ext_gnt), 64'd0);
        check_val("rst_stall", 64'(fet_arb_stall), 64'd0);
        check_val("rst_rvalid", 64'(ext_rvalid), 64'd0);
        check_val("rst_rdata", ext_rdata, 64'd0);
        check_val("rst_instr", instr_fromsram, 64'd0);
        check_val("rst_sram_cs", 64'(sram_cs), 64'd0);
        check_val("rst_sram_we", 64'(sram_we), 64'd0);
        check_val("rst_sram_adr", 64'(sram_adr), 64'd0);
        check_val("rst_sram_wdata", sram_wdata, 64'd0);
        check_val("rst_sram_wmask", 64'(sram_wmask), 64'd0);
        $display("t=%0t reset | gnt=%b stall=%b rvalid=%b instr=%h", $time, ext_gnt, fet_arb_stall, ext_rvalid, instr_fromsram);
        @(posedge clk);
        #1;
        sb_q.delete();
        e.owner = 2'(OWN_NONE);
        e.data  = 64'd0;
        sb_q.push_back(e);
        model_cnt  = 0;
        model_hold = 64'd0;
    endtask

    initial begin
        logic        pend;
        logic        cs;
        logic        rwe;
        logic [28:0] radr;
        logic [63:0] rwd;
        logic [7:0]  rwm;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = {32'(i) * 32'h9E37_79B9, ~(32'(i) * 32'h85EB_CA6B)};
            exp_mem[i] = mem[i];
        end
        @(posedge clk);
        #1;
        reset_cycle();
        reset_cycle();

        // Fetch only, then one idle cycle to collect the last beat.
        step(1'b1, 29'h20, 1'b0, 1'b0, 29'h0, 64'd0, 8'h0);
        step(1'b1, 29'h21, 1'b0, 1'b0, 29'h0, 64'd0, 8'h0);
        step(1'b0, 29'h0,  1'b0, 1'b0, 29'h0, 64'd0, 8'h0);
        // Secondary read alone; fetch must keep its held instruction.
        step(1'b0, 29'h0,  1'b1, 1'b0, 29'h8, 64'd0, 8'h0);
        step(1'b0, 29'h0,  1'b0, 1'b0, 29'h0, 64'd0, 8'h0);
        // Starvation: denied four cycles, granted in the fifth, fetch wins the sixth.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 29'(32 + i), 1'b1, 1'b0, 29'h9, 64'd0, 8'h0);
        end
        step(1'b0, 29'h0, 1'b0, 1'b0, 29'h0, 64'd0, 8'h0);
        // Masked write, then fetch the merged doubleword back.
        step(1'b0, 29'h0,  1'b1, 1'b1, 29'h21, 64'hDEADBEEF_CAFEF00D, 8'h0F);
        step(1'b1, 29'h21, 1'b0, 1'b0, 29'h0, 64'd0, 8'h0);
        step(1'b0, 29'h0,  1'b0, 1'b0, 29'h0, 64'd0, 8'h0);
        // Owner routing across back-to-back grants of different requesters.
        step(1'b0, 29'h0,  1'b1, 1'b0, 29'h10, 64'd0, 8'h0);
        step(1'b1, 29'h11, 1'b0, 1'b0, 29'h0, 64'd0, 8'h0);
        step(1'b0, 29'h0,  1'b0, 1'b0, 29'h0, 64'd0, 8'h0);
        // Reset right after a secondary read grant drops the pending beat.
        step(1'b0, 29'h0, 1'b1, 1'b0, 29'h12, 64'd0, 8'h0);
        reset_cycle();
        step(1'b0, 29'h0, 1'b0, 1'b0, 29'h0, 64'd0, 8'h0);

        // Random traffic; the secondary request is held stable until granted.
        pend = 1'b0;
        rwe  = 1'b0;
        radr = 29'h0;
        rwd  = 64'd0;
        rwm  = 8'h0;
        for (int i = 0; i < 60; i++) begin
            if (!pend && ($urandom_range(0, 2) != 0)) begin
                pend = 1'b1;
                rwe  = ($urandom_range(0, 3) == 0);
                radr = 29'($urandom_range(0, 15) + 64);
                rwd  = {$urandom, $urandom};
                rwm  = 8'($urandom_range(0, 255));
            end
            cs = ($urandom_range(0, 3) != 0);
            if (pend && (!cs || model_cnt == LIMIT)) begin
                step(cs, 29'($urandom_range(64, 79)), 1'b1, rwe, radr, rwd, rwm);
                pend = 1'b0;
            end else begin
                step(cs, 29'($urandom_range(64, 79)), pend, rwe, radr, rwd, rwm);
            end
        end
        step(1'b0, 29'h0, 1'b0, 1'b0, 29'h0, 64'd0, 8'h0);
        step(1'b0, 29'h0, 1'b0, 1'b0, 29'h0, 64'd0, 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/isram_arbiter.md
# isram_arbiter

Shares the single 64-bit instruction SRAM port between the fetch unit and one secondary requester: a program loader or debug port, or a load/store to ITCM. It sits between fetch and the SRAM macro. Fetch has priority, and the secondary requester is protected against starvation by a wait counter. The block tracks which requester owns each returned read beat, so each requester receives only its own data. When fetch is denied the port, the block stalls fetch.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of consecutive denied cycles after which the secondary requester wins over fetch. Range 1–15.

Ports:
- clk  in  1  core clock
- cpurst  in  1  reset, synchronous, active-high
- isram_cs  in  1  fetch read request
- isram_adr  in  [31:3]  fetch doubleword address
- instr_fromsram  out  64  read data returned to fetch
- fet_arb_stall  out  1  fetch request was not served this cycle; fetch must hold its PC and re-request
- ext_req  in  1  secondary request; held until granted
- ext_we  in  1  1 = write, 0 = read
- ext_adr  in  [31:3]  secondary doubleword address
- ext_wdata  in  64  write data
- ext_wmask  in  8  byte enables for writes
- ext_gnt  out  1  request accepted this cycle
- ext_rvalid  out  1  ext_rdata is valid
- ext_rdata  out  64  secondary read data
- sram_cs, sram_we  out  1  SRAM strobes
- sram_adr  out  [31:3]  SRAM address
- sram_wdata  out  64  SRAM write data
- sram_wmask  out  8  SRAM byte enables
- sram_rdata  in  64  SRAM read data; valid one cycle after a read strobe

## Operation
Grant rule (combinational, every cycle):
- While cpurst is high, all grants are 0.
- ext_gnt = ext_req & (!isram_cs | starve_hit), where starve_hit = (starve_cnt == STARVE_LIMIT).
- fet_gnt = isram_cs & !ext_gnt.
- fet_arb_stall = isram_cs & ext_gnt.

SRAM drive:
- sram_cs = fet_gnt | ext_gnt.
- The address, we, wdata and wmask come from the granted requester.
- Fetch always drives we = 0.
- When no requester is granted, the SRAM outputs are 0.

Starvation counter (starve_cnt, 4 bits):
- Increments in each cycle with ext_req & !ext_gnt, saturating at STARVE_LIMIT.
- Clears to 0 on ext_gnt or on !ext_req.

Read-owner register (rd_owner ∈ {NONE, FETCH, EXT}), updated every cycle:
- FETCH if fet_gnt.
- EXT if ext_gnt & !ext_we.
- NONE otherwise, including a granted write.

Return path:
- ext_rvalid = (rd_owner == EXT). ext_rdata = sram_rdata while ext_rvalid is 1, and 0 otherwise.
- In the cycle where rd_owner == FETCH, instr_fromsram = sram_rdata, and the same value is loaded into the 64-bit register fet_hold.
- In all other cycles, instr_fromsram = fet_hold. Fetch never sees ext data.

Boundary conditions:
- **Both requesting with the counter below the limit:** fetch wins. ext waits and its request must stay stable.
- **Starve hit:** ext wins for exactly one cycle. The counter then clears, so fetch wins the next cycle even if ext requests again.
- **ext write to an address fetch is reading in the same cycle:** cannot occur, because only one access is issued per cycle. The write is ordered by the grant.
- **Reset mid-operation:** rd_owner = NONE, so a pending ext_rvalid is dropped. starve_cnt = 0 and fet_hold = 0.

## Timing
- ext_gnt and fet_arb_stall are same-cycle combinational functions of the requests; there are no registered paths from request to grant.
- Read latency is 1 cycle from grant to data, for both requesters.
- Throughput is one access per cycle with no bubble when the port changes owner.
- Values after reset:
  - fet_arb_stall 0
  - ext_gnt 0
  - ext_rvalid 0
  - ext_rdata 0
  - instr_fromsram 0
  - all sram_* outputs 0
  - rd_owner NONE
  - starve_cnt 0
- The worst-case ext wait is STARVE_LIMIT denied cycles; the grant comes in cycle STARVE_LIMIT+1.
- The worst-case fetch loss is 1 cycle in every STARVE_LIMIT+1 cycles under a continuous ext request.

## Structure
- The shared core package holds:
  - the rd_owner encoding: NONE = 2'd0, FETCH = 2'd1, EXT = 2'd2;
  - ISRAM_AW = 29;
  - ISRAM_DW = 64.
- Sub-module arb_starve_cnt holds the saturating wait counter with compare. It is parameterised by STARVE_LIMIT and outputs starve_hit.
- The grant logic, the mux and rd_owner/fet_hold stay in the top module.

## Test plan
- **Fetch only:** isram_cs = 1 with adr 0x100>>3, then 0x108>>3 → sram_cs = 1 in both cycles. instr_fromsram equals the SRAM data one cycle later. fet_arb_stall stays 0.
- **ext only:** ext read at adr 0x40 with isram_cs = 0 → ext_gnt = 1 in the same cycle. ext_rvalid = 1 next cycle with the SRAM data. instr_fromsram keeps its prior fet_hold value.
- **Starvation, STARVE_LIMIT = 4:** isram_cs and ext_req held high → ext_gnt is 0 for 4 cycles and 1 in the 5th, where fet_arb_stall = 1. Fetch wins the 6th cycle.
- **ext write:** ext_we = 1, wmask = 0x0F, wdata = 0xDEADBEEF_CAFEF00D, fetch idle → SRAM receives the write. ext_rvalid = 0 next cycle. A fetch read of the same address afterwards returns the merged data.
- **Owner routing:** ext read granted in cycle N, fetch granted in cycle N+1 → ext_rdata holds the N+1 SRAM beat and instr_fromsram holds the N+2 beat, with no cross-contamination.
- **Reset mid-read:** assert cpurst in the cycle after an ext read grant → ext_rvalid = 0, starve_cnt = 0 and all outputs are 0 while reset is high.
